seq_mult_6b: RTL and testbench
==============================

// Module: seq_mult_6b
// PURPOSE
//  Sequential 6x6 unsigned shift-add multiplier; the control/datapath stage directly upstream of
//  adder_6b. Each iteration drives the adder operands (partial-product accumulator, gated multiplicand)
//  and consumes its sum/cout.
//  Produces a 12-bit product after 6 iterations using one adder_6b instance, no combinational multiplier.
//  Sits in the ALU multiply path; the ALU issues start and waits for done.
// PARAMETERS
//  WIDTH    6   operand width; only 6 is supported (fixed by adder_6b); other values are illegal
// PORTS
//  clk      in   1    single clock, all state updates on rising edge
//  reset    in   1    synchronous, active-high; sampled on rising edge of clk
//  start    in   1    request; sampled each rising edge, accepted only in IDLE or DONE
//  a        in   6    multiplicand, captured on the accepting edge
//  b        in   6    multiplier, captured on the accepting edge
//  busy     out  1    high while state==RUN
//  done     out  1    high for exactly one cycle (state==DONE)
//  product  out  12   a*b unsigned; registered, held until the next result is produced
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, product=0, all internal regs (M,A,Q,C,cnt) = 0.
//  Reset mid-operation: aborts immediately, same values as above; partial result discarded.
//  Registers: M[5:0] multiplicand, A[5:0] accumulator, Q[5:0] multiplier/low product, cnt[2:0].
//  Adder hookup: i0=A, i1=Q[0] ? M : 6'b0, cin=0; outputs sum[5:0], cout.
//  FSM: IDLE, RUN, DONE.
//   IDLE: start=1 -> M<=a, Q<=b, A<=0, cnt<=0, state<=RUN; start=0 -> stay.
//   RUN (one iteration per edge): {A,Q} <= {cout,sum,Q} >> 1, i.e. A<={cout,sum[5:1]}, Q<={sum[0],Q[5:1]};
//     cnt<=cnt+1; when cnt==5 on this edge -> state<=DONE and product<={final A, final Q}.
//     start ignored in RUN (no restart, no error).
//   DONE: lasts exactly one cycle; done=1. start=1 -> load as in IDLE, go RUN (back-to-back allowed);
//     start=0 -> IDLE.
//  Latency: accepting edge = edge 0; RUN edges 1..6; done high in the cycle following edge 6.
//   Throughput: one result per 7 cycles with back-to-back starts.
//  Width: cout always captured into A[5] during shift; product never overflows (max 63*63=3969=12'hF81).
//  product updates only on the RUN->DONE edge; holds value through IDLE and the next RUN.
//  a, b may change freely after the accepting edge; they are not re-sampled.
//  busy=1 exactly for the 6 RUN cycles; busy and done never high together.
//  cnt wraps never: leaves RUN at cnt==5; cnt cleared on every load.
// TESTING
//  reset, a=63,b=63, start 1 cycle -> busy 6 cycles, done pulse 1 cycle, product=12'hF81 (3969)
//  a=5,b=7 -> product=35; then a=0,b=45 -> product=0 (previous 35 held until that done)
//  a=9,b=3 started; start pulsed again with a=1,b=1 during RUN -> ignored, product=27
//  start held high continuously, a=2,b=3 -> done every 7th cycle, product=6, no IDLE cycles
//  a=63,b=1 run, assert reset at RUN cycle 3 -> next cycle IDLE, busy=0, done=0, product=0; no done
//  exhaustive sweep a,b in 0..63 vs reference a*b; check done count == start-accept count

Source files
------------

// File: rtl/seq_mult_6b.sv
// Sequential 6x6 unsigned shift-add multiplier: one 6-bit adder per iteration,
// 12-bit product after six RUN cycles, IDLE/RUN/DONE handshake toward the ALU.

module adder_6b (
  input  logic [5:0] i0,
  input  logic [5:0] i1,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);
  assign {cout, sum} = 7'(i0) + 7'(i1) + 7'(cin);
endmodule

module seq_mult_6b #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product
);
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_i1;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Partial-product step: add the multiplicand only when the current multiplier bit is set.
  assign add_i1 = q_reg[0] ? m_reg : '0;

  adder_6b u_adder (
    .i0   (a_reg),
    .i1   (add_i1),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            a_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Shift {cout,sum,Q} right by one; cout lands in the accumulator MSB.
          a_reg <= {add_cout, add_sum[WIDTH-1:1]};
          q_reg <= {add_sum[0], q_reg[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            product <= {add_cout, add_sum, q_reg[WIDTH-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_6b.sv
// Scoreboard bench for seq_mult_6b: driver queues expected products, a negedge
// monitor pops and checks them whenever done is presented.

module tb_seq_mult_6b;
  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] product;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int accept_count = 0;
  int cyc = 0;
  int busy_run = 0;
  bit prev_done = 1'b0;
  logic [11:0] sb[$];
  int done_cyc[$];

  seq_mult_6b dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each presented result against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
      end
      if (busy) busy_run++;
      if (done) begin
        logic [11:0] exp;
        done_count++;
        done_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: product=%0d with no pending expectation", product);
        end else begin
          exp = sb.pop_front();
          if (product !== exp) begin
            errors++;
            $display("FAIL product: got %0d, required %0d", product, exp);
          end
        end
        checks++;
        if (busy_run != 6) begin
          errors++;
          $display("FAIL busy_len: got %0d busy cycles, required 6", busy_run);
        end
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_pulse: done high in consecutive cycles, required one-cycle pulse");
        end
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Issue one operation, then wait (bounded) for done; leaves start low at done.
  task automatic run_op(input logic [5:0] xa, input logic [5:0] xb, input logic [11:0] exp,
                        input int hold_exp, input bit poke);
    bit seen;
    a = xa; b = xb; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    accept_count++;
    start = 1'b0;
    a = 6'($urandom); b = 6'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (poke && i == 1) begin a = 6'd1; b = 6'd1; start = 1'b1; end
      if (poke && i == 2) start = 1'b0;
      @(posedge clk); #1;
      if (hold_exp >= 0 && i == 2) check("held_product", int'(product), hold_exp);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 12 cycles for a=%0d b=%0d", xa, xb);
    end
  endtask

  initial begin
    int dc;
    bit seen;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(6'd63, 6'd63, 12'hF81, -1, 1'b0);
    @(posedge clk); #1;
    run_op(6'd5, 6'd7, 12'd35, -1, 1'b0);
    @(posedge clk); #1;
    run_op(6'd0, 6'd45, 12'd0, 35, 1'b0);
    @(posedge clk); #1;
    run_op(6'd9, 6'd3, 12'd27, -1, 1'b1);
    @(posedge clk); #1;

    // Continuous start: three back-to-back results, one every 7 cycles.
    done_cyc.delete();
    a = 6'd2; b = 6'd3; start = 1'b1;
    sb.push_back(12'd6);
    @(posedge clk); #1;
    accept_count++;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (done) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL cont_timeout: no done for continuous op %0d", k);
      end
      if (k < 2) begin sb.push_back(12'd6); accept_count++; end
      else start = 1'b0;
    end
    @(posedge clk); #1;
    check("cont_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("cont_gap0", done_cyc[1] - done_cyc[0], 7);
      check("cont_gap1", done_cyc[2] - done_cyc[1], 7);
    end

    // Abort mid-run with reset: no done, everything cleared.
    a = 6'd63; b = 6'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    reset = 1'b0;
    dc = done_count;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_count, dc);

    // Exhaustive sweep, issued back-to-back off each done.
    for (int ia = 0; ia < 64; ia++)
      for (int ib = 0; ib < 64; ib++)
        run_op(6'(ia), 6'(ib), 12'(ia * ib), -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("done_vs_accept", done_count, accept_count);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
